// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker request issuer: access/mode enums,
// the MMPT register snapshot, the walker transaction and issuer FSM states.
package mpt_pkg;

  localparam int unsigned MPTW_ID_W = 4;

  typedef enum logic [3:0] {
    MMPT_BARE    = 4'd0,
    MMPT_SMMPT34 = 4'd1,
    MMPT_SMMPT43 = 4'd2,
    MMPT_SMMPT52 = 4'd3
  } mmpt_mode_e;

  typedef struct packed {
    mmpt_mode_e  mode;
    logic [5:0]  sdid;
    logic [43:0] ppn;
  } mmpt_reg_t;

  typedef enum logic [1:0] {
    ACCESS_READ  = 2'd0,
    ACCESS_WRITE = 2'd1,
    ACCESS_EXEC  = 2'd2
  } mpt_access_e;

  typedef enum logic [1:0] {
    MPT_WALKING_IDLE = 2'd0,
    MPT_WALKING_DO   = 2'd1,
    MPT_WALKING_DONE = 2'd2
  } mpt_walking_e;

  typedef enum logic [1:0] {
    NO_ERROR   = 2'd0,
    PPN_ERROR  = 2'd1,
    MODE_ERROR = 2'd2
  } mpt_format_error_e;

  typedef struct packed {
    logic                   valid;
    logic [63:0]            spa;
    mmpt_reg_t              mmpt;
    mpt_walking_e           walking;
    mpt_format_error_e      format_error;
    logic                   access_error;
    logic [1:0]             level;
    mpt_access_e            access;
    logic [MPTW_ID_W-1:0]   id;
  } mptw_transaction_t;

  typedef enum logic [1:0] {
    ISS_RUN   = 2'd0,
    ISS_FLUSH = 2'd1,
    ISS_DRAIN = 2'd2
  } iss_state_e;

endpackage

// File: rtl/mptw_req_fifo.sv
// Registered request FIFO (no bypass), power-of-two depth.
// Ports: clk_i/rst_i/flush_i, push_i/data_i, pop_i/data_o, full_o, empty_o.
module mptw_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem[rptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= data_i;
  end

endmodule

// File: rtl/mptw_request_issuer.sv
// Buffers core MPT-check requests and issues packed walker transactions,
// bounding in-flight work; flush empties the buffer then drains the pipe.
// Ports: req_* core side, stage_master_* walker side, rsp_done_i completion,
// flush_i, outstanding_o in-flight count, busy_o activity.
module mptw_request_issuer
  import mpt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ID_WIDTH        = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [63:0]                          req_spa_i,
  input  logic [$bits(mmpt_reg_t)-1:0]         req_mmpt_i,
  input  logic [$bits(mpt_access_e)-1:0]       req_access_i,
  input  logic [ID_WIDTH-1:0]                  req_id_i,
  output logic [$bits(mptw_transaction_t)-1:0] stage_master_data,
  output logic                                 stage_master_valid,
  input  logic                                 stage_master_ready,
  input  logic                                 rsp_done_i,
  input  logic                                 flush_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned TXN_W = $bits(mptw_transaction_t);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  iss_state_e        state_q;
  iss_state_e        state_d;
  logic [CNT_W-1:0]  out_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              done;
  logic              run;
  mptw_transaction_t txn_in;
  logic [TXN_W-1:0]  head;

  always_comb begin
    txn_in              = '0;
    txn_in.valid        = 1'b1;
    txn_in.spa          = req_spa_i;
    txn_in.mmpt         = req_mmpt_i;
    txn_in.walking      = MPT_WALKING_DO;
    txn_in.format_error = NO_ERROR;
    txn_in.access_error = 1'b0;
    txn_in.access       = mpt_access_e'(req_access_i);
    txn_in.id           = MPTW_ID_W'(req_id_i);
  end

  assign run = (state_q == ISS_RUN);

  assign req_ready_o = run && !fifo_full && !rst_i;
  assign stage_master_valid =
    run && !fifo_empty && (out_q < MAX_CNT);
  // Head RAM is not reset; hide it until it holds a live entry.
  assign stage_master_data =
    stage_master_valid ? head : '0;

  // A push racing a flush is dropped; a handshake racing it still counts.
  assign push = req_valid_i && req_ready_o && !flush_i;
  assign pop  = stage_master_valid && stage_master_ready;
  assign done = rsp_done_i && (out_q != '0);

  mptw_req_fifo #(
    .WIDTH (TXN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (state_q == ISS_FLUSH),
    .push_i  (push),
    .data_i  (txn_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
    end else if (pop && !done) begin
      out_q <= out_q + 1'b1;
    end else if (done && !pop) begin
      out_q <= out_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ISS_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ISS_RUN:   if (flush_i) state_d = ISS_FLUSH;
      ISS_FLUSH: state_d = ISS_DRAIN;
      ISS_DRAIN: begin
        if (!flush_i && out_q == '0) state_d = ISS_RUN;
      end
      default:   state_d = ISS_RUN;
    endcase
  end

  assign outstanding_o = out_q;
  assign busy_o = !fifo_empty || (out_q != '0) || !run;

endmodule

// File: tb/tb_mptw_request_issuer.sv
// Scoreboard bench for mptw_request_issuer: directed scenarios then
// randomized traffic against a queue-based reference model.
module tb_mptw_request_issuer;
  import mpt_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
  localparam int IDW   = 4;
  localparam int TW    = $bits(mptw_transaction_t);
  localparam int OW    = $clog2(MAXO+1);

  logic                         clk_i = 1'b0;
  logic                         rst_i = 1'b1;
  logic                         req_valid_i = 1'b0;
  logic                         req_ready_o;
  logic [63:0]                  req_spa_i = '0;
  logic [$bits(mmpt_reg_t)-1:0] req_mmpt_i = '0;
  logic [1:0]                   req_access_i = '0;
  logic [IDW-1:0]               req_id_i = '0;
  logic [TW-1:0]                stage_master_data;
  logic                         stage_master_valid;
  logic                         stage_master_ready = 1'b0;
  logic                         rsp_done_i = 1'b0;
  logic                         flush_i = 1'b0;
  logic [OW-1:0]                outstanding_o;
  logic                         busy_o;

  mptw_request_issuer #(
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .ID_WIDTH        (IDW)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_spa_i          (req_spa_i),
    .req_mmpt_i         (req_mmpt_i),
    .req_access_i       (req_access_i),
    .req_id_i           (req_id_i),
    .stage_master_data  (stage_master_data),
    .stage_master_valid (stage_master_valid),
    .stage_master_ready (stage_master_ready),
    .rsp_done_i         (rsp_done_i),
    .flush_i            (flush_i),
    .outstanding_o      (outstanding_o),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [255:0] act,
                       logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic mptw_transaction_t mk_txn();
    mptw_transaction_t t;
    t              = '0;
    t.valid        = 1'b1;
    t.spa          = req_spa_i;
    t.mmpt         = req_mmpt_i;
    t.walking      = MPT_WALKING_DO;
    t.format_error = NO_ERROR;
    t.access       = mpt_access_e'(req_access_i);
    t.id           = req_id_i;
    return t;
  endfunction

  // Reference model: buffered count, in-flight count, flush phase.
  typedef enum int {M_RUN, M_FLUSH, M_DRAIN} mphase_e;
  mphase_e           ph = M_RUN;
  int                occ = 0;
  int                outs = 0;
  bit                after_rst = 1'b1;
  mptw_transaction_t sb[$];

  always @(negedge clk_i) begin : model
    bit er, ev, hs, acc, dn;
    int o0;
    er = !rst_i && ph == M_RUN && occ < DEPTH;
    ev = ph == M_RUN && occ > 0 && outs < MAXO;
    check("req_ready", req_ready_o, er);
    check("master_valid", stage_master_valid, ev);
    check("outstanding", outstanding_o, outs);
    check("busy", busy_o, occ > 0 || outs > 0 || ph != M_RUN);
    if (after_rst) check("reset_data", stage_master_data, '0);
    after_rst = 1'b0;
    if (rst_i) begin
      ph = M_RUN; occ = 0; outs = 0;
      sb.delete();
      after_rst = 1'b1;
    end else begin
      o0  = outs;
      hs  = ev && stage_master_ready;
      acc = er && req_valid_i && !flush_i;
      dn  = rsp_done_i && outs > 0;
      if (hs) occ--;
      if (acc) begin
        occ++;
        sb.push_back(mk_txn());
      end
      outs = outs + int'(hs) - int'(dn);
      case (ph)
        M_RUN:   if (flush_i) ph = M_FLUSH;
        M_FLUSH: begin
          occ = 0;
          sb.delete();
          ph = M_DRAIN;
        end
        default: if (!flush_i && o0 == 0) ph = M_RUN;
      endcase
    end
  end

  // Monitor: pops expected transactions on handshakes, checks stability.
  bit                hold = 1'b0;
  logic [TW-1:0]     hold_data;
  mptw_transaction_t exp_t;

  always @(negedge clk_i) begin : monitor
    if (rst_i) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", stage_master_valid, 1);
        check("hold_data", stage_master_data, hold_data);
      end
      if (stage_master_valid && stage_master_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL txn_data: got %0h expected none",
                   stage_master_data);
        end else begin
          exp_t = sb.pop_front();
          check("txn_data", stage_master_data, exp_t);
        end
      end
      hold = stage_master_valid && !stage_master_ready && !flush_i;
      hold_data = stage_master_data;
    end
  end

  task automatic set_in(input bit v, input bit r, input bit d,
                        input bit f, input bit rs);
    mmpt_reg_t m;
    req_valid_i        = v;
    stage_master_ready = r;
    rsp_done_i         = d;
    flush_i            = f;
    rst_i              = rs;
    req_spa_i          = {$urandom, $urandom};
    m.mode             = mmpt_mode_e'($urandom_range(0, 3));
    m.sdid             = 6'($urandom);
    m.ppn              = {12'($urandom), $urandom};
    req_mmpt_i         = m;
    req_access_i       = 2'($urandom_range(0, 2));
    req_id_i           = IDW'($urandom);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input bit v, input bit r, input bit d,
                     input bit f, input bit rs);
    set_in(v, r, d, f, rs);
    tick();
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
  endtask

  mptw_transaction_t t;
  mmpt_reg_t         mm;

  initial begin
    do_reset();

    // Single request, immediate issue
    set_in(1, 1, 0, 0, 0);
    mm = '0;
    mm.mode = MMPT_SMMPT43;
    mm.ppn  = 44'h12345;
    req_spa_i  = 64'h0000_0080_0000_1000;
    req_mmpt_i = mm;
    req_id_i   = 4'd3;
    tick();
    set_in(0, 1, 0, 0, 0);
    @(negedge clk_i);
    t = stage_master_data;
    check("r38_valid", stage_master_valid, 1);
    check("r38_walking", t.walking, MPT_WALKING_DO);
    check("r38_id", t.id, 3);
    check("r38_spa", t.spa, 64'h0000_0080_0000_1000);
    tick();
    set_in(0, 1, 0, 0, 0);
    @(negedge clk_i);
    check("r38_outstanding", outstanding_o, 1);
    tick();

    // Back-pressure fills the FIFO
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 0);
      if (i == 4) begin
        @(negedge clk_i);
        check("r39_ready", req_ready_o, 0);
        check("r39_head", stage_master_data, sb[0]);
      end
      tick();
    end
    repeat (6) cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 0, 0);

    // Outstanding limit
    do_reset();
    repeat (9) cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    set_in(0, 1, 0, 0, 0);
    @(negedge clk_i);
    check("r40_valid_low", stage_master_valid, 0);
    check("r40_out8", outstanding_o, 8);
    tick();
    cyc(0, 1, 1, 0, 0);
    set_in(0, 1, 0, 0, 0);
    @(negedge clk_i);
    check("r40_release", stage_master_valid, 1);
    tick();
    repeat (9) cyc(0, 1, 1, 0, 0);

    // Simultaneous issue/complete and saturation at zero
    do_reset();
    repeat (2) cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("r41_same", outstanding_o, 2);
    tick();
    repeat (2) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("r41_sat0", outstanding_o, 0);
    tick();

    // Flush with buffered and in-flight work
    do_reset();
    repeat (2) cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("r42_flush_ready", req_ready_o, 0);
    tick();
    set_in(1, 1, 0, 0, 0);
    @(negedge clk_i);
    check("r42_drain_ready", req_ready_o, 0);
    check("r42_drain_valid", stage_master_valid, 0);
    tick();
    repeat (2) cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("r42_run_ready", req_ready_o, 1);
    check("r42_idle", busy_o, 0);
    tick();

    // Reset mid-traffic
    do_reset();
    repeat (2) cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("r43_valid", stage_master_valid, 0);
    check("r43_data", stage_master_data, '0);
    check("r43_out", outstanding_o, 0);
    check("r43_busy", busy_o, 0);
    check("r43_ready", req_ready_o, 1);
    tick();

    // Randomized traffic, light then heavy completion rates
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 99) < ((i < 2000) ? 12 : 45),
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 299) == 0);
    end
    repeat (4) cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
